// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect board push-buttons,
// then keep a sticky per-button press-event register cleared by a masked ack.
//
// Parameters:
//   N               number of buttons
//   DEBOUNCE_CYCLES consecutive disagreeing cycles needed to flip a level
//   ACTIVE_LOW      1 = pin reads 0 while pressed
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   btn_raw[N]      raw asynchronous button pins
//   btn_level[N]    debounced state, 1 = pressed
//   btn_press[N]    one-cycle pulse on a debounced 0->1 flip
//   btn_release[N]  one-cycle pulse on a debounced 1->0 flip
//   evt_pending[N]  sticky press flags
//   evt_any         OR of evt_pending
//   evt_ack         single-cycle acknowledge strobe
//   evt_ack_mask[N] flags to clear when evt_ack is high
module btn_conditioner #(
    parameter int N               = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] evt_pending,
    output logic         evt_any,
    input  logic         evt_ack,
    input  logic [N-1:0] evt_ack_mask
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERM     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0]  IDLE_PIN = {N{ACTIVE_LOW}};

    // Two-flop synchroniser, held at the released pin value in reset so
    // that leaving reset never looks like a fresh edge.
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;
    logic [N-1:0] p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Normalised press value: 1 means pressed, regardless of pin polarity.
    assign p = sync2_q ^ IDLE_PIN;

    // Debounce state per bit is the (level, counter) pair: a zero counter
    // with level 0/1 is idle/pressed, a non-zero counter is counting
    // toward the opposite level.
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [N-1:0]  level_q;
    logic [N-1:0]  level_d;
    logic [N-1:0]  press_q;
    logic [N-1:0]  press_d;
    logic [N-1:0]  rel_q;
    logic [N-1:0]  rel_d;
    logic [N-1:0]  pend_q;
    logic [N-1:0]  pend_d;
    logic [N-1:0]  ack_clr;

    always_comb begin
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (p[i] != level_q[i]) begin
                if (cnt_q[i] == TERM) begin
                    // Enough consecutive disagreement: commit the flip.
                    level_d[i] = p[i];
                    press_d[i] = p[i];
                    rel_d[i]   = ~p[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // Agreement (including a glitch back) leaves cnt_d at 0.
        end
    end

    // A press landing on the same edge as its ack keeps the flag set.
    assign ack_clr = {N{evt_ack}} & evt_ack_mask;
    assign pend_d  = press_d | (pend_q & ~ack_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            pend_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            pend_q  <= pend_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = rel_q;
    assign evt_pending = pend_q;
    assign evt_any     = |pend_q;

endmodule
